// File: rtl/ctrl_bubble_stage_if.sv
// ctrl_bubble_stage_if: control-word and hazard handshake bundle between the
// decode/hazard side (master) and the decode-to-execute control register (slave).
//   ctrl_in/valid_in : decoded control word and its valid flag
//   hz/hz_len        : hazard request and requested bubble count
//   flush/stall_ds   : stage kill and downstream stall
//   ctrl_out/valid_out : registered control word towards execute
//   stall_us         : combinational upstream freeze
interface ctrl_bubble_stage_if #(
  parameter int unsigned CTRL_W  = 7,
  parameter int unsigned MAX_BUB = 3
);
  localparam int unsigned BW = $clog2(MAX_BUB + 1);

  logic [CTRL_W-1:0] ctrl_in;
  logic              valid_in;
  logic              hz;
  logic [BW-1:0]     hz_len;
  logic              flush;
  logic              stall_ds;
  logic [CTRL_W-1:0] ctrl_out;
  logic              valid_out;
  logic              stall_us;

  modport master (
    output ctrl_in, valid_in, hz, hz_len, flush, stall_ds,
    input  ctrl_out, valid_out, stall_us
  );

  modport slave (
    input  ctrl_in, valid_in, hz, hz_len, flush, stall_ds,
    output ctrl_out, valid_out, stall_us
  );
endinterface

// File: rtl/ctrl_bubble_stage.sv
// ctrl_bubble_stage: decode-to-execute control register with multi-cycle
// bubble insertion. Captures the control word, holds on downstream stall,
// zeroes on flush, and on a hazard inserts 1..MAX_BUB zero cycles while
// freezing upstream.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus        : ctrl_bubble_stage_if.slave (ctrl/valid in+out, hz, hz_len,
//                flush, stall_ds, stall_us)
//   bubble_cnt : saturating count of bubbles written (only when the macro
//                CTRL_BUBBLE_STATS_EN is defined)
module ctrl_bubble_stage #(
  parameter int unsigned CTRL_W  = 7,
  parameter int unsigned MAX_BUB = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ctrl_bubble_stage_if.slave   bus
`ifdef CTRL_BUBBLE_STATS_EN
  ,
  output logic [CNT_W-1:0]     bubble_cnt
`endif
);
  localparam int unsigned BW = $clog2(MAX_BUB + 1);

  if (MAX_BUB < 1 || CNT_W < 1) begin : g_bad_param
    $error("ctrl_bubble_stage: MAX_BUB and CNT_W must be >= 1");
  end

  typedef enum logic {
    S_RUN    = 1'b0,
    S_BUBBLE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     rem_q, rem_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [BW-1:0]     len_c;
  logic              hz_take_c;
  logic              bub_wr_c;

  // Clamp the request and decide whether RUN accepts a hazard this cycle.
  always_comb begin
    len_c     = (bus.hz_len > BW'(MAX_BUB)) ? BW'(MAX_BUB) : bus.hz_len;
    hz_take_c = (state_q == S_RUN) && bus.hz && (len_c != '0);
  end

  // Next-state: flush beats stall_ds beats the state action.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    bub_wr_c = 1'b0;
    if (bus.flush) begin
      state_d = S_RUN;
      rem_d   = '0;
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (!bus.stall_ds) begin
      unique case (state_q)
        S_RUN: begin
          if (hz_take_c) begin
            ctrl_d   = '0;
            valid_d  = 1'b0;
            rem_d    = BW'(len_c - BW'(1));
            state_d  = (len_c > BW'(1)) ? S_BUBBLE : S_RUN;
            bub_wr_c = 1'b1;
          end else begin
            ctrl_d  = bus.valid_in ? bus.ctrl_in : '0;
            valid_d = bus.valid_in;
          end
        end
        S_BUBBLE: begin
          ctrl_d   = '0;
          valid_d  = 1'b0;
          rem_d    = BW'(rem_q - BW'(1));
          bub_wr_c = 1'b1;
          if (rem_q == BW'(1)) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      rem_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ctrl_out  = ctrl_q;
  assign bus.valid_out = valid_q;
  // Upstream freeze is combinational so the PC holds in the very cycle the hazard is seen.
  assign bus.stall_us  = bus.stall_ds | (state_q == S_BUBBLE) | (hz_take_c & ~bus.flush);

`ifdef CTRL_BUBBLE_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating bubble counter; flush/stall/reset edges never count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bub_wr_c && !bus.flush && !bus.stall_ds && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bubble_cnt = cnt_q;
`else
  logic unused_bub_wr;
  assign unused_bub_wr = bub_wr_c;
`endif
endmodule

// File: tb/tb_ctrl_bubble_stage.sv
module tb_ctrl_bubble_stage;
  localparam int unsigned CTRL_W  = 7;
  localparam int unsigned MAX_BUB = 3;
  localparam int unsigned BW      = $clog2(MAX_BUB + 1);
`ifdef CTRL_BUBBLE_STATS_EN
  localparam int unsigned CNT_W   = 2;
`else
  localparam int unsigned CNT_W   = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_bubble_stage_if #(.CTRL_W(CTRL_W), .MAX_BUB(MAX_BUB)) bus ();
`ifdef CTRL_BUBBLE_STATS_EN
  logic [CNT_W-1:0] bubble_cnt;
`endif

  ctrl_bubble_stage #(.CTRL_W(CTRL_W), .MAX_BUB(MAX_BUB), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef CTRL_BUBBLE_STATS_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  // kind: 0 = stall_us, 1 = ctrl_out/valid_out, 2 = bubble_cnt
  typedef struct {
    int              at;
    int              kind;
    logic [CTRL_W-1:0] ctrl;
    logic            valid;
    logic            stall;
    int              cnt;
    string           name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input string name, input int at, input int kind,
                      input logic [CTRL_W-1:0] c, input logic v, input logic s, input int n);
    exp_t e;
    e.name = name; e.at = at; e.kind = kind;
    e.ctrl = c; e.valid = v; e.stall = s; e.cnt = n;
    q.push_back(e);
  endtask

  // One cycle: drive inputs, expect stall_us now and outputs after the edge.
  task automatic step(input string name, input logic [CTRL_W-1:0] c, input logic v,
                      input logic h, input logic [2:0] len, input logic fl, input logic sd,
                      input logic es, input logic [CTRL_W-1:0] ec, input logic ev);
    bus.ctrl_in  = c;
    bus.valid_in = v;
    bus.hz       = h;
    bus.hz_len   = BW'(len);
    bus.flush    = fl;
    bus.stall_ds = sd;
    push(name, cyc, 0, '0, 1'b0, es, 0);
    push(name, cyc + 1, 1, ec, ev, 1'b0, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string name, input int n);
    push(name, cyc, 2, '0, 1'b0, 1'b0, n);
  endtask

  // Monitor: pops every expectation that is due this cycle and compares.
  exp_t m;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      m = q.pop_front();
      total++;
      if (m.at < cyc) begin
        bad++;
        $display("FAIL %s late-check at=%0d now=%0d", m.name, m.at, cyc);
      end else if (m.kind == 0) begin
        if (bus.stall_us !== m.stall) begin
          bad++;
          $display("FAIL %s stall_us got=%0b want=%0b", m.name, bus.stall_us, m.stall);
        end
      end else if (m.kind == 1) begin
        if (bus.ctrl_out !== m.ctrl || bus.valid_out !== m.valid) begin
          bad++;
          $display("FAIL %s ctrl/valid got=%h/%0b want=%h/%0b", m.name,
                   bus.ctrl_out, bus.valid_out, m.ctrl, m.valid);
        end
      end else begin
`ifdef CTRL_BUBBLE_STATS_EN
        if (int'(bubble_cnt) != m.cnt) begin
          bad++;
          $display("FAIL %s bubble_cnt got=%0d want=%0d", m.name, bubble_cnt, m.cnt);
        end
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ctrl_in = '0; bus.valid_in = 1'b0; bus.hz = 1'b0;
    bus.hz_len = '0; bus.flush = 1'b0; bus.stall_ds = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push("reset_stall", cyc, 0, '0, 1'b0, 1'b0, 0);
    push("reset_out", cyc, 1, '0, 1'b0, 1'b0, 0);
    check_cnt("reset_cnt", 0);

    //    name         ctrl   v  hz len fl sd   stall exp_ctrl ev
    step("pass0",      7'h5A, 1, 0, 0, 0, 0,    0,    7'h5A,   1);
    step("pass1",      7'h5A, 1, 0, 0, 0, 0,    0,    7'h5A,   1);
    step("pass2",      7'h5A, 1, 0, 0, 0, 0,    0,    7'h5A,   1);
    // two bubbles; hz kept high in BUBBLE is ignored
    step("hz2_b0",     7'h33, 1, 1, 2, 0, 0,    1,    7'h00,   0);
    step("hz2_b1",     7'h33, 1, 1, 2, 0, 0,    1,    7'h00,   0);
    step("hz2_cap",    7'h33, 1, 0, 0, 0, 0,    0,    7'h33,   1);
    // request 7 on a 2-bit field -> 3 bubbles
    step("hz7_b0",     7'h44, 1, 1, 7, 0, 0,    1,    7'h00,   0);
    step("hz7_b1",     7'h44, 1, 0, 0, 0, 0,    1,    7'h00,   0);
    step("hz7_b2",     7'h44, 1, 0, 0, 0, 0,    1,    7'h00,   0);
    step("hz7_cap",    7'h44, 1, 0, 0, 0, 0,    0,    7'h44,   1);
    step("hz0_none",   7'h55, 1, 1, 0, 0, 0,    0,    7'h55,   1);
    // flush on the second bubble
    step("fl_b0",      7'h66, 1, 1, 3, 0, 0,    1,    7'h00,   0);
    step("fl_kill",    7'h66, 1, 0, 0, 1, 0,    1,    7'h00,   0);
    step("fl_resume",  7'h11, 1, 0, 0, 0, 0,    0,    7'h11,   1);
    step("fl_hz_same", 7'h22, 1, 1, 2, 1, 0,    0,    7'h00,   0);
    step("fl_hz_next", 7'h22, 1, 0, 0, 0, 0,    0,    7'h22,   1);
    step("fl_run",     7'h23, 1, 0, 0, 1, 0,    0,    7'h00,   0);
    // downstream stall in the middle of a 3-bubble run
    step("sd_b0",      7'h77, 1, 1, 3, 0, 0,    1,    7'h00,   0);
    step("sd_hold0",   7'h77, 1, 0, 0, 0, 1,    1,    7'h00,   0);
    step("sd_hold1",   7'h77, 1, 0, 0, 0, 1,    1,    7'h00,   0);
    step("sd_b1",      7'h77, 1, 0, 0, 0, 0,    1,    7'h00,   0);
    step("sd_b2",      7'h77, 1, 0, 0, 0, 0,    1,    7'h00,   0);
    step("sd_cap",     7'h77, 1, 0, 0, 0, 0,    0,    7'h77,   1);
    step("sd_run_hold",7'h78, 1, 0, 0, 0, 1,    1,    7'h77,   1);
    step("invalid_in", 7'h7F, 0, 0, 0, 0, 0,    0,    7'h00,   0);
    // reset in the middle of a bubble run
    step("rst_b0",     7'h01, 1, 1, 3, 0, 0,    1,    7'h00,   0);
    rst = 1'b1;
    step("rst_mid",    7'h01, 1, 0, 0, 0, 0,    1,    7'h00,   0);
    rst = 1'b0;
    step("rst_run",    7'h02, 1, 0, 0, 0, 0,    0,    7'h02,   1);
    check_cnt("cnt_after_rst", 0);
    // single bubbles back to back; counter saturates at 3 when enabled
    for (int i = 0; i < 5; i++) begin
      step("single_bub", 7'h0C, 1, 1, 1, 0, 0,  1,    7'h00,   0);
      check_cnt("cnt_single", (i + 1 > 3) ? 3 : i + 1);
    end
    step("single_cap", 7'h0C, 1, 0, 0, 0, 0,    0,    7'h0C,   1);
    rst = 1'b1;
    step("cnt_rst",    7'h0C, 1, 0, 0, 0, 0,    0,    7'h00,   0);
    rst = 1'b0;
    check_cnt("cnt_cleared", 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ctrl_bubble_stage.md
# ctrl_bubble_stage

Parametrised pipeline register for decoded control bits between decode and execute. It captures the control word each cycle, holds it on downstream stall, and zeroes it on flush. On a hazard request it inserts a programmable run of 1 to MAX_BUB consecutive bubbles while stalling the upstream stages. This block is the registered, multi-cycle successor to the single-cycle control-zeroing mux in the hazard path.

## Interface
- CTRL_W, 7, width of the control word
- MAX_BUB, 3, maximum bubbles per hazard request (≥1)
- BW, $clog2(MAX_BUB+1), width of the hazard-length field (derived; do not override)
- CNT_W, 16, width of the bubble statistics counter
- clk  input  1  rising-edge clock; only clock
- rst  input  1  synchronous, active-high reset
- ctrl_in  input  CTRL_W  control word from decode
- valid_in  input  1  ctrl_in carries a real instruction
- hz  input  1  hazard request from hazard unit
- hz_len  input  BW  bubbles requested; 0 means no hazard; values >MAX_BUB are clamped to MAX_BUB
- flush  input  1  kill the stage (branch taken / redirect)
- stall_ds  input  1  downstream stall; hold the register
- ctrl_out  output  CTRL_W  registered control word to execute
- valid_out  output  1  ctrl_out is a real instruction
- stall_us  output  1  combinational upstream stall (freeze PC and IF/ID)
- bubble_cnt  output  CNT_W  hazard bubbles inserted (only with CTRL_BUBBLE_STATS_EN)

## Operation
- States: RUN, BUBBLE. Internal remaining-bubble counter rem, width BW. L = min(hz_len, MAX_BUB).
- Per-edge priority: rst > flush > stall_ds > state action.
- rst: ctrl_out=0, valid_out=0, state=RUN, rem=0, bubble_cnt=0.
- flush: ctrl_out←0, valid_out←0, state←RUN, rem←0. This aborts any bubble sequence in progress. Not counted as a bubble.
- stall_ds (no flush): ctrl_out, valid_out, state, rem and bubble_cnt all hold.
- RUN, hz=1, L≠0:
  - ctrl_out←0, valid_out←0, rem←L−1.
  - state←BUBBLE if L>1, else stays RUN.
- RUN, otherwise: ctrl_out←(valid_in ? ctrl_in : 0), valid_out←valid_in.
- BUBBLE: ctrl_out←0, valid_out←0, rem←rem−1; state←RUN when rem==1. hz is ignored in BUBBLE.
- Net effect: exactly L zero cycles are issued per accepted hazard. The instruction held upstream is then captured on the first RUN cycle.
- stall_us = stall_ds | (state==BUBBLE) | (state==RUN & hz & L≠0 & ~flush).
- When valid_out=0, ctrl_out is always 0; no stale control bits leak.

## Timing
- Latency is 1 cycle, ctrl_in to ctrl_out, in RUN with no stall.
- stall_us is purely combinational from state, hz, hz_len, flush and stall_ds. There is no registered delay.
- A hazard accepted at edge k yields bubbles visible after edges k…k+L−1. The held instruction appears after edge k+L, provided no stall_ds occurs. Each stall_ds cycle extends this by one.
- flush and hz in the same cycle: flush wins. No bubbles are issued and stall_us=0.
- flush during BUBBLE: the sequence ends immediately and RUN resumes next cycle.
- rst mid-BUBBLE: the next state is RUN with all outputs at their reset values.

## Configuration
- CTRL_BUBBLE_STATS_EN defined:
  - bubble_cnt exists.
  - Increments by 1 on every edge that writes a hazard bubble (RUN-with-hazard or BUBBLE, not flush, not stall_ds, not rst).
  - Saturates at 2^CNT_W−1. Reset value is 0.
- Undefined: the bubble_cnt port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then valid_in=1, ctrl_in=7'h5A for 3 cycles → ctrl_out=7'h5A and valid_out=1 from the edge after capture; stall_us=0.
- hz=1, hz_len=2, ctrl_in=7'h33 held while stall_us=1 → ctrl_out=0 for 2 cycles, then 7'h33; stall_us high for exactly 2 cycles; bubble_cnt +2.
- hz_len=7 with MAX_BUB=3 → exactly 3 bubbles, then the held word; hz_len=0 with hz=1 → no bubble, stall_us=0.
- hz_len=3, flush asserted on the second bubble cycle → next ctrl_out=0, state RUN, stall_us=0; the following ctrl_in=7'h11 appears one cycle later.
- stall_ds=1 for 2 cycles mid-BUBBLE → ctrl_out and rem hold; the bubble total is still 3; stall_us=1 throughout.
- With stats enabled, CNT_W=2: issue 5 single bubbles → bubble_cnt saturates at 3; rst pulse → 0.
